// File: rtl/pipe_delay_line.sv
// pipe_delay_line: parametrised register delay line with a valid bit per stage.
// Data and valid bits advance one stage per enabled edge. The line can also
// stall, clear synchronously and expose any stage through a runtime tap
// select. A registered fill counter tracks how many stages hold valid data.
module pipe_delay_line #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SELW  = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SELW-1:0]        dly_sel,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [CNTW-1:0]        fill_cnt,
  output logic                   full
);

  localparam logic [SELW-1:0] LAST_SEL  = SELW'(DEPTH - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [CNTW-1:0]  fill_q;
  logic [SELW-1:0]  sel_eff;

  // Stage data and valid bits: reset/clear to zero, otherwise shift when enabled.
  // NOTE: non-blocking assignments make every stage take its predecessor's
  // pre-edge value; blocking ones would ripple new data through the whole chain.
  // NOTE: the data registers are deliberately reset, because taps and out_data
  // must read zero during reset, not just be qualified by a cleared valid bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      vld_q <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      vld_q <= '0;
    end else if (en) begin
      stage_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      vld_q <= {vld_q[DEPTH-2:0], in_valid};
    end
  end

  // Occupancy counter: one valid beat enters at stage 0, one may leave the last stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_q <= '0;
    end else if (clr) begin
      fill_q <= '0;
    end else if (en) begin
      case ({in_valid, vld_q[DEPTH-1]})
        2'b10:   fill_q <= fill_q + CNTW'(1);
        2'b01:   fill_q <= fill_q - CNTW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Tap select clamp; out-of-range indices only exist when DEPTH is not a power of two.
  if ((2 ** SELW) > DEPTH) begin : g_clamp
    always_comb begin
      // NOTE: default assignment first so every path drives sel_eff (no latch).
      sel_eff = dly_sel;
      if (dly_sel > LAST_SEL) sel_eff = LAST_SEL;
    end
  end else begin : g_no_clamp
    assign sel_eff = dly_sel;
  end

  assign out_data  = stage_q[sel_eff];
  assign out_valid = vld_q[sel_eff];

  // Flatten all stages onto the taps bus, stage i at bits [i*WIDTH +: WIDTH].
  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = stage_q[g];
  end

  assign fill_cnt = fill_q;
  assign full     = (fill_q == DEPTH_CNT);

`ifndef SYNTHESIS
  // The counter is a shortcut for the population count of the valid bits.
  a_fill_matches_vld: assert property (@(posedge clk) disable iff (!rstn)
    fill_q == CNTW'($countones(vld_q)));
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// tb_pipe_delay_line: three instances (8x4, 8x3, 1x2) share one input stream.
// The reference keeps the most recent accepted beats, newest first. Stage i of
// any instance is simply the i-th newest beat since the last clear/reset.
module tb_pipe_delay_line;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       en, clr, in_valid;
  logic [7:0] in_data;
  logic [1:0] sel4, sel3;
  logic       sel2;

  logic        out_valid4, out_valid3, out_valid2;
  logic [7:0]  out_data4, out_data3;
  logic        out_data2;
  logic [31:0] taps4;
  logic [23:0] taps3;
  logic [1:0]  taps2;
  logic [2:0]  fill4;
  logic [1:0]  fill3, fill2;
  logic        full4, full3, full2;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  pipe_delay_line #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .in_valid(in_valid),
    .in_data(in_data), .dly_sel(sel4), .out_valid(out_valid4),
    .out_data(out_data4), .taps(taps4), .fill_cnt(fill4), .full(full4)
  );

  pipe_delay_line #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .in_valid(in_valid),
    .in_data(in_data), .dly_sel(sel3), .out_valid(out_valid3),
    .out_data(out_data3), .taps(taps3), .fill_cnt(fill3), .full(full3)
  );

  pipe_delay_line #(.WIDTH(1), .DEPTH(2)) u_d2 (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .in_valid(in_valid),
    .in_data(in_data[0]), .dly_sel(sel2), .out_valid(out_valid2),
    .out_data(out_data2), .taps(taps2), .fill_cnt(fill2), .full(full2)
  );

  // Reference history of accepted beats, newest at index 0.
  beat_t hist[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn || clr) begin
      hist.delete();
    end else if (en) begin
      hist.push_front({in_valid, in_data});
      if (hist.size() > 4) void'(hist.pop_back());
    end
  end

  function automatic beat_t age(int k);
    if (k < hist.size()) return hist[k];
    return '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the history model.
  always @(negedge clk) begin
    beat_t       b;
    logic [31:0] e4, e3, e2;
    int          f4, f3, f2, s3;
    if (chk_on) begin
      e4 = '0; e3 = '0; e2 = '0;
      f4 = 0;  f3 = 0;  f2 = 0;
      for (int i = 0; i < 4; i++) begin
        b = age(i);
        e4[i*8 +: 8] = b.d;
        if (b.v) f4++;
        if (i < 3) begin
          e3[i*8 +: 8] = b.d;
          if (b.v) f3++;
        end
        if (i < 2) begin
          e2[i] = b.d[0];
          if (b.v) f2++;
        end
      end
      check("d4_taps", taps4, e4);
      check("d4_fill", 32'(fill4), 32'(f4));
      check("d4_full", 32'(full4), 32'(f4 == 4));
      b = age(int'(sel4));
      check("d4_out", 32'({out_valid4, out_data4}), 32'({b.v, b.d}));

      check("d3_taps", 32'(taps3), e3);
      check("d3_fill", 32'(fill3), 32'(f3));
      check("d3_full", 32'(full3), 32'(f3 == 3));
      s3 = (sel3 > 2'd2) ? 2 : int'(sel3);
      b = age(s3);
      check("d3_out", 32'({out_valid3, out_data3}), 32'({b.v, b.d}));

      check("d2_taps", 32'(taps2), e2);
      check("d2_fill", 32'(fill2), 32'(f2));
      check("d2_full", 32'(full2), 32'(f2 == 2));
      b = age(int'(sel2));
      check("d2_out", 32'({out_valid2, out_data2}), 32'({b.v, b.d[0]}));
    end
  end

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic e, input logic c, input logic v, input logic [7:0] d);
    en = e; clr = c; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  int occ_exp[6] = '{1, 1, 2, 3, 2, 3};
  logic occ_pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] clamp_exp[4] = '{8'd10, 8'd20, 8'd30, 8'd30};

  initial begin
    rstn = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    sel4 = '0; sel3 = '0; sel2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_taps", taps4, 32'h0);
    check("rst_fill", 32'(fill4), 32'h0);
    check("rst_oval", 32'(out_valid4), 32'h0);
    check("rst_full", 32'(full4), 32'h0);
    rstn = 1'b1;
    chk_on = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // Alignment: tap 2 shows a beat on the third edge counting its sampling edge.
    sel4 = 2'd2;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'(8'h11 * (k + 1)));
      check("align_tap0", 32'(taps4[7:0]), 32'(8'h11 * (k + 1)));
      if (k == 1) check("align_early", 32'(out_valid4), 32'h0);
      if (k == 2) check("align_out", 32'({out_valid4, out_data4}), 32'h111);
    end

    // Stall: contents and occupancy hold while inputs wiggle.
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b1, 8'(8'hA0 + k));
    check("stall_fill_pre", taps4, 32'hA0A1_A2A3);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'($urandom), 8'($urandom));
      check("stall_taps", taps4, 32'hA0A1_A2A3);
      check("stall_fill", 32'(fill4), 32'd4);
    end
    cyc(1'b1, 1'b0, 1'b1, 8'hA4);
    check("stall_resume", taps4, 32'hA1A2_A3A4);

    // Occupancy pattern after a clear.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, occ_pat[k], 8'(k));
      check("occ_fill", 32'(fill4), 32'(occ_exp[k]));
    end
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'(8'hC0 + k));
      check("occ_full", 32'(full4), 32'(k >= 3));
    end

    // Clear beats enable; the input of the clear cycle is dropped.
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    check("clr_taps", taps4, 32'h0);
    check("clr_fill", 32'(fill4), 32'h0);
    check("clr_oval", 32'(out_valid4), 32'h0);

    // Tap switch and clamp on the depth-3 instance: stages {30,20,10}.
    cyc(1'b1, 1'b0, 1'b1, 8'd30);
    cyc(1'b1, 1'b0, 1'b1, 8'd20);
    cyc(1'b1, 1'b0, 1'b1, 8'd10);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel3 = 2'(k);
      #1;
      check("clamp_out", 32'(out_data3), 32'(clamp_exp[k]));
    end

    // Asynchronous reset mid-cycle with a loaded line.
    #1;
    rstn = 1'b0;
    #1;
    check("arst_taps", taps4, 32'h0);
    check("arst_oval", 32'(out_valid4), 32'h0);
    check("arst_fill", 32'(fill4), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Randomised regression across all three instances.
    for (int k = 0; k < 1500; k++) begin
      sel4 = 2'($urandom);
      sel3 = 2'($urandom);
      sel2 = 1'($urandom);
      cyc(1'($urandom_range(3) != 0), 1'($urandom_range(19) == 0),
          1'($urandom), 8'($urandom));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
